wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Schedules the single register-file write port between the pipeline writeback
//  stream (MEM/WB stage outputs) and a multi-cycle unit (mul/div) result stream.
//  Pipeline has priority. MC results wait in a small FIFO. A starvation counter
//  forces a one-cycle pipeline stall so a waiting MC result is always written.
//  Sits between the MEM/WB register and the register file.
// PARAMETERS
//  DATA_W        32  register data width
//  ADDR_W        5   register address width
//  DEPTH         2   MC result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive denials of FIFO head before forced stall (>=1)
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       synchronous reset, active-low
//  wb_en_in         in   1       pipeline writeback request
//  mem_r_en_in      in   1       1: write mem_read_val_in, 0: write alu_res_in
//  alu_res_in       in   DATA_W  pipeline ALU result
//  mem_read_val_in  in   DATA_W  pipeline load data
//  dest_in          in   ADDR_W  pipeline destination register
//  mc_valid         in   1       MC result valid
//  mc_ready         out  1       FIFO can accept (push = mc_valid & mc_ready)
//  mc_dest          in   ADDR_W  MC destination register
//  mc_data          in   DATA_W  MC result
//  rf_we            out  1       register-file write enable (registered)
//  rf_waddr         out  ADDR_W  register-file write address (registered)
//  rf_wdata         out  DATA_W  register-file write data (registered)
//  pipe_stall       out  1       hold MEM/WB and upstream stages this cycle (registered)
//  fifo_count       out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst==0 at edge): rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, FIFO emptied,
//   fifo_count=0, wait_cnt=0, state IDLE. mc_ready=0 while rst==0. Mid-op reset discards
//   queued MC results and any pending forced stall.
//  pipe_req = wb_en_in & (dest_in!=0). Writes to register 0 are never issued.
//  Pipeline data = mem_r_en_in ? mem_read_val_in : alu_res_in.
//  FIFO: mc_ready = (fifo_count<DEPTH). Push with mc_dest==0 is accepted and dropped.
//   No push when full, even if a pop happens in the same cycle. No bypass: an entry
//   pushed in cycle N is eligible from N+1. Pointers wrap modulo DEPTH.
//  States: IDLE (FIFO empty), PEND (FIFO non-empty), FORCE (pipe_stall=1).
//  Grant per cycle:
//   FORCE: grant FIFO head. Pipeline not written; it is held by pipe_stall and is
//     presented again next cycle. Next state is PEND if entries remain, else IDLE.
//   else pipe_req: grant pipeline. If FIFO non-empty, head is denied.
//   else FIFO non-empty: grant FIFO head (pop).
//   else: no write.
//  Granted write appears on rf_* at next edge (latency 1). rf_we=0 when no grant.
//   rf_waddr and rf_wdata hold their last values when rf_we=0.
//  wait_cnt: clears on every pop and in IDLE. Increments on each denial of the head.
//   A denial with wait_cnt==STARVE_LIMIT-1 moves the state to FORCE, so pipe_stall=1
//   for exactly one cycle after STARVE_LIMIT consecutive denials.
//  IDLE->PEND on push. PEND->IDLE when the last entry pops with no simultaneous push.
//  Pop and push in the same cycle: count unchanged.
//  No ordering check between pipeline and MC writes to the same register. Later
//   grant wins.
// TESTING
//  1 wb_en=1,mem_r_en=1,mem_read_val=0xDEADBEEF,dest=5 -> next cycle rf_we=1,waddr=5,
//    wdata=0xDEADBEEF. Same with mem_r_en=0, alu_res=0x12 -> wdata=0x12.
//  2 wb_en=1,dest=0 -> rf_we=0. mc push dest=0 -> mc_ready=1, fifo_count stays 0.
//  3 pipeline idle, mc push dest=7,data=0xA5 in cycle N -> pop N+1, rf_we=1,waddr=7,
//    wdata=0xA5 at N+2. fifo_count returns to 0.
//  4 STARVE_LIMIT=4, pipe_req every cycle, one MC push -> 4 pipeline writes, then
//    pipe_stall=1 for 1 cycle and MC write, then held pipeline entry written. No
//    pipeline write lost or duplicated.
//  5 pipeline busy, push 2 MC results -> fifo_count=2, mc_ready=0. Third mc_valid
//    stalls until a pop. Entries written in push order.
//  6 fifo_count=2, state FORCE, rst=0 one cycle -> rf_we=0, pipe_stall=0,
//    fifo_count=0, mc_ready=1 after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Shares one write port between the pipeline writeback stream and a small FIFO
// of multi-cycle unit results. The pipeline normally wins. When the FIFO head has
// been passed over too many times in a row, a one-cycle pipeline stall is forced
// so that the head can be written.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic [DATA_W-1:0]          alu_res_in,
    input  logic [DATA_W-1:0]          mem_read_val_in,
    input  logic [ADDR_W-1:0]          dest_in,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [ADDR_W-1:0]          mc_dest,
    input  logic [DATA_W-1:0]          mc_data,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic                       pipe_stall,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [PW-1:0]       rd_ptr_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [WW-1:0]       wait_q;
    logic [ADDR_W-1:0]   fifo_dest_q [DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [DEPTH];

    logic                pipe_req_s;
    logic [DATA_W-1:0]   pipe_data_s;
    logic                fifo_nempty_s;
    logic                push_s;
    logic                pop_s;
    logic                grant_pipe_s;
    logic                deny_s;
    logic                force_s;
    logic                starve_s;

    // Accepting a new MC result only depends on current occupancy, never on a pop this cycle.
    assign mc_ready   = rst & (count_q < CW'(DEPTH));
    assign fifo_count = count_q;

    // Per-cycle grant decision between the pipeline and the FIFO head.
    always_comb begin
        pipe_req_s    = wb_en_in & (dest_in != {ADDR_W{1'b0}});
        pipe_data_s   = mem_r_en_in ? mem_read_val_in : alu_res_in;
        fifo_nempty_s = (count_q != {CW{1'b0}});
        force_s       = (state_q == ST_FORCE);
        // Results aimed at register 0 are handshaken but never stored.
        push_s        = mc_valid & mc_ready & (mc_dest != {ADDR_W{1'b0}});
        pop_s         = 1'b0;
        grant_pipe_s  = 1'b0;
        deny_s        = 1'b0;
        if (force_s) begin
            pop_s = 1'b1;
        end else if (pipe_req_s) begin
            grant_pipe_s = 1'b1;
            deny_s       = fifo_nempty_s;
        end else if (fifo_nempty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        starve_s = deny_s & (wait_q == WW'(STARVE_LIMIT - 1));
        count_d  = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end

    // FIFO storage: written on push only, no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_dest_q[wr_ptr_q] <= mc_dest;
            fifo_data_q[wr_ptr_q] <= mc_data;
        end
    end

    // Arbiter FSM with FIFO bookkeeping, starvation counter and registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            wait_q     <= {WW{1'b0}};
            rf_we      <= 1'b0;
            rf_waddr   <= {ADDR_W{1'b0}};
            rf_wdata   <= {DATA_W{1'b0}};
            pipe_stall <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            // Write port: address/data hold their last values when idle.
            rf_we <= grant_pipe_s | pop_s;
            if (grant_pipe_s) begin
                rf_waddr <= dest_in;
                rf_wdata <= pipe_data_s;
            end else if (pop_s) begin
                rf_waddr <= fifo_dest_q[rd_ptr_q];
                rf_wdata <= fifo_data_q[rd_ptr_q];
            end

            case (state_q)
                ST_FORCE: begin
                    pipe_stall <= 1'b0;
                    wait_q     <= {WW{1'b0}};
                    state_q    <= (count_d != {CW{1'b0}}) ? ST_PEND : ST_IDLE;
                end
                ST_IDLE, ST_PEND: begin
                    if (starve_s) begin
                        // Head passed over STARVE_LIMIT times: stall the pipe next cycle.
                        pipe_stall <= 1'b1;
                        wait_q     <= {WW{1'b0}};
                        state_q    <= ST_FORCE;
                    end else if (deny_s) begin
                        pipe_stall <= 1'b0;
                        wait_q     <= wait_q + WW'(1);
                        state_q    <= ST_PEND;
                    end else begin
                        pipe_stall <= 1'b0;
                        if (pop_s || (count_d == {CW{1'b0}})) begin
                            wait_q <= {WW{1'b0}};
                        end
                        state_q <= (count_d != {CW{1'b0}}) ? ST_PEND : ST_IDLE;
                    end
                end
                default: begin
                    pipe_stall <= 1'b0;
                    wait_q     <= {WW{1'b0}};
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
